planificador_ultrasonido: RTL and testbench
===========================================

Name: planificador_ultrasonido

Overview:
Round-robin scheduler that shares one trigger/measure engine among N HC-SR04-style ultrasonic sensors. It fires one sensor at a time and measures its echo width in centimetres. A guard interval between shots prevents acoustic crosstalk. Each shot yields one result: distance, sensor id and detection flag. The result stream feeds the object counter and the LCD path in place of a single free-running sensor controller.

Parameters:
N_SENSORS, 4, number of sensors sequenced (2..8)
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
CYCLES_PER_CM, 2915, echo-high clk cycles per cm of distance (50e6*2/34300, truncated)
TIMEOUT_CYCLES, 1_500_000, max cycles from trigger fall to echo fall (30 ms)
GUARD_CYCLES, 500_000, idle cycles after each shot before the next sensor (10 ms)
DIST_THRESHOLD_CM, 50, detection threshold; detected when distance < threshold

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable_i  in  1  run scheduling; when low, finish the current shot and then idle
echo_i  in  N_SENSORS  raw echo inputs, asynchronous
trigger_o  out  N_SENSORS  one-hot trigger; at most one bit high at a time
dist_valid_o  out  1  one-cycle result strobe
dist_cm_o  out  8  distance of the strobed result, saturated at 255
dist_id_o  out  3  sensor index of the strobed result
timeout_o  out  1  one-cycle strobe, coincident with dist_valid_o when the shot timed out
object_detected_o  out  N_SENSORS  per-sensor detection flag, held between results
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0; state=IDLE; sensor pointer=0; all counters 0.
- Echo inputs pass through 2-flop synchronizers. All decisions use the synchronized echo of the currently selected sensor only.
- IDLE: if enable_i=1, go to TRIG next cycle.
- TRIG: trigger_o[ptr]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. The timeout counter clears on entry to WAIT_RISE.
- WAIT_RISE: needs a synced low-to-high edge. An echo already high on entry is stale and does not count until it has been seen low. On the edge, go to MEASURE with the cm counter and sub-counter at 0.
- MEASURE: the sub-counter counts echo-high cycles. On reaching CYCLES_PER_CM-1 it wraps and cm increments. cm saturates at 255 and stays there.
- Falling edge in MEASURE: next cycle dist_valid_o=1, dist_cm_o=cm, dist_id_o=ptr. object_detected_o[ptr] is updated to (cm < DIST_THRESHOLD_CM); other bits are unchanged. Then go to GUARD.
- Timeout: the timeout counter runs in WAIT_RISE and MEASURE. When it reaches TIMEOUT_CYCLES, dist_valid_o=1, timeout_o=1, dist_cm_o=255 and object_detected_o[ptr]=0; go to GUARD. If the echo falls in the same cycle the timeout is reached, the echo-fall result wins and timeout_o=0.
- GUARD: count GUARD_CYCLES, then advance ptr (wraps N_SENSORS-1 -> 0). Go to TRIG if enable_i=1, otherwise go to IDLE.
- enable_i dropping mid-shot has no effect until GUARD ends; the result is still produced.
- Echo activity on unselected sensors is ignored.
- dist_cm_o and dist_id_o hold their last values between strobes.
- Reset asserted mid-shot: trigger_o drops immediately. The next shot after release starts at sensor 0.
- Latency: dist_valid_o comes 3 cycles after the raw echo falls (2 synchronizer cycles + 1).

Decomposition:
- Shared header file ultrasonido_defs.vh holds:
  - state encodings IDLE/TRIG/WAIT_RISE/MEASURE/GUARD;
  - the speed-of-sound constant 34300;
  - the default CLOCK_FREQ.
- Sub-module medidor_eco contains the synchronized-echo edge detection, the sub-counter/cm counter with saturation, and the timeout counter. It has start/clear inputs and done/timeout/cm outputs.
- The scheduler FSM, pointer and output registers stay in the top module.

Test Plan:
All tests use TRIG_CYCLES=10, CYCLES_PER_CM=4, TIMEOUT_CYCLES=2000, GUARD_CYCLES=50, N_SENSORS=4, DIST_THRESHOLD_CM=50.
1. Basic measurement: enable_i=1, echo[0] rises 20 cycles after trigger fall and stays high 80 cycles -> trigger_o=0001 for 10 cycles; dist_valid_o with dist_cm_o=20, dist_id_o=0, object_detected_o[0]=1, 3 cycles after the echo falls.
2. Round-robin: every sensor echoes 240 cycles -> ids 0,1,2,3,0 in order; dist_cm_o=60 each; object_detected_o=0000; trigger_o never has more than one bit set.
3. Timeout: no echo on sensor 2 -> strobe with timeout_o=1, dist_cm_o=255, dist_id_o=2, 2000 cycles after trigger fall; object_detected_o[2] cleared.
4. Saturation and stale echo: echo[1] held high from before the trigger -> no measurement until it goes low. Then a 1200-cycle high pulse -> dist_cm_o=255, timeout_o=0.
5. Enable drop and async reset: drop enable_i during MEASURE -> result still strobed, then IDLE with busy_o=0. Assert rst_n=0 mid-TRIG -> trigger_o=0 in the same cycle; after release the first shot is sensor 0.

Source files
------------

// File: rtl/planificador_ultrasonido_pkg.sv
// rtl/planificador_ultrasonido_pkg.sv - shared constants, state encoding and timing helpers
//
// Purpose: state encoding for the ultrasonic scheduler, the speed-of-sound and
// default clock constants, and the default timing values derived from them.
// Ports: none (package).
package planificador_ultrasonido_pkg;

  localparam int unsigned CLOCK_FREQ     = 50_000_000;
  localparam int unsigned SOUND_CM_PER_S = 34300;

  // Round trip: echo width covers twice the distance, so cycles/cm = f*2/c.
  function automatic int unsigned cycles_per_cm(input int unsigned clk_hz);
    longint unsigned num;
    num = longint'(clk_hz) * 64'd2;
    return int'(num / longint'(SOUND_CM_PER_S));
  endfunction

  localparam int unsigned DEF_TRIG_CYCLES    = CLOCK_FREQ / 100_000;  // 10 us
  localparam int unsigned DEF_TIMEOUT_CYCLES = (CLOCK_FREQ / 100) * 3; // 30 ms
  localparam int unsigned DEF_GUARD_CYCLES   = CLOCK_FREQ / 100;      // 10 ms

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_GUARD
  } state_t;

endpackage

// File: rtl/planificador_ultrasonido_medidor_eco.sv
// rtl/planificador_ultrasonido_medidor_eco.sv - echo edge detection, cm counter and timeout for one shot
//
// Purpose: measures the width of the selected (already synchronized) echo in cm.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_clear        clear counters for a new shot (asserted the cycle before WAIT_RISE)
//   i_wait_rise    scheduler is waiting for the echo to rise
//   i_measure      scheduler is measuring the echo-high time
//   i_echo         synchronized echo of the selected sensor
//   o_rise         valid rising edge seen (not pre-empted by timeout)
//   o_done         echo fell while measuring
//   o_timeout      timeout reached without an echo fall in the same cycle
//   o_cm           measured distance, saturated at 255
module planificador_ultrasonido_medidor_eco #(
  parameter int unsigned CYCLES_PER_CM  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_wait_rise,
  input  logic       i_measure,
  input  logic       i_echo,
  output logic       o_rise,
  output logic       o_done,
  output logic       o_timeout,
  output logic [7:0] o_cm
);

  localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [SUB_W-1:0] r_sub;
  logic [7:0]       r_cm;
  logic [TO_W-1:0]  r_to;
  logic             r_seen_low;

  logic w_active, w_rise, w_fall, w_to_hit, w_count;

  always_comb begin
    w_active = i_wait_rise | i_measure;
    // An echo already high when waiting starts is stale: it must be seen low first.
    w_rise   = i_wait_rise & i_echo & r_seen_low;
    w_fall   = i_measure & ~i_echo;
    w_to_hit = w_active & (r_to == TO_LAST);
    // The rising-edge cycle is itself the first echo-high cycle, counted from zero.
    w_count  = i_echo & (w_rise | i_measure);
  end

  assign o_rise    = w_rise & ~w_to_hit;
  assign o_done    = w_fall;
  assign o_timeout = w_to_hit & ~w_fall;
  assign o_cm      = r_cm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub      <= '0;
      r_cm       <= '0;
      r_to       <= '0;
      r_seen_low <= 1'b0;
    end else if (i_clear) begin
      r_sub      <= '0;
      r_cm       <= '0;
      r_to       <= '0;
      r_seen_low <= 1'b0;
    end else begin
      if (w_active && !w_to_hit) begin
        r_to <= r_to + TO_W'(1);
      end
      if (i_wait_rise && !i_echo) begin
        r_seen_low <= 1'b1;
      end
      if (w_count) begin
        if (r_sub == SUB_LAST) begin
          r_sub <= '0;
          if (r_cm != 8'hFF) begin
            r_cm <= r_cm + 8'd1;
          end
        end else begin
          r_sub <= r_sub + SUB_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/planificador_ultrasonido.sv
// rtl/planificador_ultrasonido.sv - round-robin scheduler sharing one echo engine among N sensors
//
// Purpose: fires one sensor at a time, measures its echo in cm, then waits a
// guard interval before moving to the next sensor.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   enable_i            run scheduling; dropping it lets the current shot finish
//   echo_i[N]           raw asynchronous echo inputs
//   trigger_o[N]        one-hot trigger of the selected sensor
//   dist_valid_o        one-cycle result strobe
//   dist_cm_o, dist_id_o  distance and sensor index of the last result (held)
//   timeout_o           strobe coincident with dist_valid_o on a timed-out shot
//   object_detected_o[N] per-sensor detection flag (held)
//   busy_o              scheduler not in IDLE
module planificador_ultrasonido
  import planificador_ultrasonido_pkg::*;
#(
  parameter int unsigned N_SENSORS         = 4,
  parameter int unsigned TRIG_CYCLES       = DEF_TRIG_CYCLES,
  parameter int unsigned CYCLES_PER_CM     = cycles_per_cm(CLOCK_FREQ),
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
  parameter int unsigned GUARD_CYCLES      = DEF_GUARD_CYCLES,
  parameter int unsigned DIST_THRESHOLD_CM = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [N_SENSORS-1:0] echo_i,
  output logic [N_SENSORS-1:0] trigger_o,
  output logic                 dist_valid_o,
  output logic [7:0]           dist_cm_o,
  output logic [2:0]           dist_id_o,
  output logic                 timeout_o,
  output logic [N_SENSORS-1:0] object_detected_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_MAX = (TRIG_CYCLES > GUARD_CYCLES) ? TRIG_CYCLES : GUARD_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [2:0]       PTR_LAST   = 3'(N_SENSORS - 1);
  localparam logic [7:0]       THRESH     = 8'(DIST_THRESHOLD_CM);

  state_t                 r_state, w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_ptr;
  logic [N_SENSORS-1:0]   r_sync1, r_sync2;
  logic                   r_valid, r_timeout;
  logic [7:0]             r_cm;
  logic [2:0]             r_id;
  logic [N_SENSORS-1:0]   r_det;

  logic [N_SENSORS-1:0]   w_sel_onehot;
  logic                   w_echo_sel, w_trig_end, w_guard_end;
  logic                   w_rise, w_done, w_timeout;
  logic [7:0]             w_cm;

  always_comb begin
    w_sel_onehot = '0;
    w_echo_sel   = 1'b0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (r_ptr == 3'(i)) begin
        w_sel_onehot[i] = 1'b1;
        w_echo_sel      = r_sync2[i];
      end
    end
  end

  planificador_ultrasonido_medidor_eco #(
    .CYCLES_PER_CM (CYCLES_PER_CM),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_medidor (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_trig_end),
    .i_wait_rise(r_state == ST_WAIT_RISE),
    .i_measure  (r_state == ST_MEASURE),
    .i_echo     (w_echo_sel),
    .o_rise     (w_rise),
    .o_done     (w_done),
    .o_timeout  (w_timeout),
    .o_cm       (w_cm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_trig_end  = (r_state == ST_TRIG)  && (r_cnt == TRIG_LAST);
    w_guard_end = (r_state == ST_GUARD) && (r_cnt == GUARD_LAST);
    // Combinational from the state register so an async reset drops it at once.
    trigger_o   = (r_state == ST_TRIG) ? w_sel_onehot : '0;
    busy_o      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:      if (enable_i) w_next = ST_TRIG;
      ST_TRIG:      if (w_trig_end) w_next = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (w_timeout)   w_next = ST_GUARD;
        else if (w_rise) w_next = ST_MEASURE;
      end
      ST_MEASURE:   if (w_done || w_timeout) w_next = ST_GUARD;
      ST_GUARD:     if (w_guard_end) w_next = enable_i ? ST_TRIG : ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= echo_i;
      r_sync2 <= r_sync1;
      if (r_state == ST_TRIG || r_state == ST_GUARD) begin
        r_cnt <= (w_trig_end || w_guard_end) ? '0 : r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_guard_end) begin
        r_ptr <= (r_ptr == PTR_LAST) ? 3'd0 : r_ptr + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_cm      <= '0;
      r_id      <= '0;
      r_det     <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      // The echo fall wins over a timeout reached in the same cycle (see o_timeout).
      if (w_done) begin
        r_valid <= 1'b1;
        r_cm    <= w_cm;
        r_id    <= r_ptr;
        r_det   <= (r_det & ~w_sel_onehot) | ((w_cm < THRESH) ? w_sel_onehot : '0);
      end else if (w_timeout) begin
        r_valid   <= 1'b1;
        r_timeout <= 1'b1;
        r_cm      <= 8'hFF;
        r_id      <= r_ptr;
        r_det     <= r_det & ~w_sel_onehot;
      end
    end
  end

  assign dist_valid_o      = r_valid;
  assign timeout_o         = r_timeout;
  assign dist_cm_o         = r_cm;
  assign dist_id_o         = r_id;
  assign object_detected_o = r_det;

endmodule

// File: tb/tb_planificador_ultrasonido.sv
// tb/tb_planificador_ultrasonido.sv - directed self-checking bench for planificador_ultrasonido
module tb_planificador_ultrasonido;

  localparam int N     = 4;
  localparam int TRIG  = 10;
  localparam int CPC   = 4;
  localparam int TO    = 2000;
  localparam int GUARD = 50;
  localparam int THR   = 50;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable_i;
  logic [N-1:0] echo_i;
  logic [N-1:0] trigger_o;
  logic         dist_valid_o;
  logic [7:0]   dist_cm_o;
  logic [2:0]   dist_id_o;
  logic         timeout_o;
  logic [N-1:0] object_detected_o;
  logic         busy_o;

  int n_total = 0;
  int n_bad   = 0;
  int n_valid = 0;
  int n_multi = 0;

  planificador_ultrasonido #(
    .N_SENSORS        (N),
    .TRIG_CYCLES      (TRIG),
    .CYCLES_PER_CM    (CPC),
    .TIMEOUT_CYCLES   (TO),
    .GUARD_CYCLES     (GUARD),
    .DIST_THRESHOLD_CM(THR)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_i         (enable_i),
    .echo_i           (echo_i),
    .trigger_o        (trigger_o),
    .dist_valid_o     (dist_valid_o),
    .dist_cm_o        (dist_cm_o),
    .dist_id_o        (dist_id_o),
    .timeout_o        (timeout_o),
    .object_detected_o(object_detected_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (dist_valid_o === 1'b1) n_valid++;
    if ($countones(trigger_o) > 1) n_multi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // One shot on sensor sid. stale: echo held high from before the trigger for
  // that many cycles after trigger fall; pre: low cycles before the pulse;
  // width: pulse length (0 = no echo, expect timeout); drop_at: pulse cycle at
  // which enable_i is dropped (-1 = never).
  task automatic shot(input int sid, input int stale, input int pre, input int width,
                      input int drop_at, input logic [7:0] exp_cm, input logic exp_to);
    int n;
    int v0;
    logic [N-1:0] exp_trig;
    exp_trig = 4'b0001 << sid;
    if (stale > 0) echo_i[sid] = 1'b1;
    n = 0;
    while (trigger_o == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("trig_seen", 32'(trigger_o != '0), 1);
    check_eq("trig_sel", 32'(trigger_o), 32'(exp_trig));
    n = 0;
    while (trigger_o != '0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("trig_len", n, TRIG);
    v0 = n_valid;
    if (stale > 0) begin
      repeat (stale) @(negedge clk);
      echo_i[sid] = 1'b0;
    end
    repeat (pre) @(negedge clk);
    if (width > 0) begin
      echo_i[sid] = 1'b1;
      for (int i = 0; i < width; i++) begin
        if (i == drop_at) enable_i = 1'b0;
        @(negedge clk);
      end
      echo_i[sid] = 1'b0;
      check_eq("no_early_valid", n_valid - v0, 0);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dist_valid_o !== 1'b1 && n < 2500);
    check_eq("latency", n, (width > 0) ? 3 : TO);
    check_eq("dist_cm", 32'(dist_cm_o), 32'(exp_cm));
    check_eq("dist_id", 32'(dist_id_o), sid);
    check_eq("timeout", 32'(timeout_o), 32'(exp_to));
    @(negedge clk);
    check_eq("strobe_once", n_valid - v0, 1);
    check_eq("valid_low", 32'(dist_valid_o), 0);
    check_eq("cm_hold", 32'(dist_cm_o), 32'(exp_cm));
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    enable_i = 1'b0;
    echo_i   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_trig", 32'(trigger_o), 0);
    check_eq("rst_valid", 32'(dist_valid_o), 0);
    check_eq("rst_cm", 32'(dist_cm_o), 0);
    check_eq("rst_id", 32'(dist_id_o), 0);
    check_eq("rst_to", 32'(timeout_o), 0);
    check_eq("rst_det", 32'(object_detected_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", 32'(busy_o), 0);
    enable_i = 1'b1;

    // basic measurement: 80 cycles / 4 = 20 cm, below threshold
    shot(0, 0, 20, 80, -1, 8'd20, 1'b0);
    check_eq("det_t1", 32'(object_detected_o), 32'(4'b0001));

    // round robin, 240 cycles = 60 cm on every sensor
    shot(1, 0, 7, 240, -1, 8'd60, 1'b0);
    shot(2, 0, 7, 240, -1, 8'd60, 1'b0);
    shot(3, 0, 7, 240, -1, 8'd60, 1'b0);
    shot(0, 0, 7, 240, -1, 8'd60, 1'b0);
    check_eq("det_rr", 32'(object_detected_o), 0);

    // set detections so the timeout has something to clear
    shot(1, 0, 5, 40, -1, 8'd10, 1'b0);
    check_eq("det_s1", 32'(object_detected_o), 32'(4'b0010));
    shot(2, 0, 5, 12, -1, 8'd3, 1'b0);
    check_eq("det_s2", 32'(object_detected_o), 32'(4'b0110));
    shot(3, 0, 5, 240, -1, 8'd60, 1'b0);
    shot(0, 0, 5, 240, -1, 8'd60, 1'b0);

    // stale echo then 1200-cycle pulse saturates at 255 without timeout
    shot(1, 30, 20, 1200, -1, 8'd255, 1'b0);
    check_eq("det_sat", 32'(object_detected_o), 32'(4'b0100));

    // no echo on sensor 2: timeout
    shot(2, 0, 0, 0, -1, 8'd255, 1'b1);
    check_eq("det_to", 32'(object_detected_o), 0);

    // enable drop during measure: result still produced, then idle
    shot(3, 0, 5, 100, 50, 8'd25, 1'b0);
    check_eq("det_drop", 32'(object_detected_o), 32'(4'b1000));
    repeat (60) @(negedge clk);
    check_eq("drop_busy", 32'(busy_o), 0);
    check_eq("drop_trig", 32'(trigger_o), 0);

    enable_i = 1'b1;
    shot(0, 0, 5, 8, -1, 8'd2, 1'b0);
    check_eq("det_pre_rst", 32'(object_detected_o), 32'(4'b1001));

    // async reset in the middle of sensor 1 trigger
    n = 0;
    while (trigger_o == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("trig_s1", 32'(trigger_o), 32'(4'b0010));
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_trig", 32'(trigger_o), 0);
    check_eq("arst_busy", 32'(busy_o), 0);
    check_eq("arst_det", 32'(object_detected_o), 0);
    check_eq("arst_cm", 32'(dist_cm_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    shot(0, 0, 5, 40, -1, 8'd10, 1'b0);

    check_eq("onehot", n_multi, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
